// File: rtl/nn_pkg.sv
// Shared fixed-point type, FSM encoding and geometry helpers for the nn streaming blocks.
package nn_pkg;
   localparam int Q_WIDTH = 16;

   typedef logic signed [Q_WIDTH-1:0] q8_8_t;

   typedef enum logic {ST_FILL = 1'b0, ST_EMIT = 1'b1} unpool_state_t;

   function automatic int idx_width(input int k);
      int w;
      w = $clog2(k * k);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unpool_dim(input int in_dim, input int k);
      return in_dim * k;
   endfunction
endpackage

// File: rtl/unpool_row_buf.sv
// One pooled row of {value, argmax index}; written during FILL, read by column during EMIT.
module unpool_row_buf #(
   parameter int IN_W  = 2,
   parameter int WIDTH = 16,
   parameter int IDX_W = 2,
   parameter int PW_W  = 1
) (
   input  logic             i_clk,
   input  logic             i_wr_en,
   input  logic [PW_W-1:0]  i_wr_pw,
   input  logic [WIDTH-1:0] i_wr_val,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [PW_W-1:0]  i_rd_pw,
   output logic [WIDTH-1:0] o_rd_val,
   output logic [IDX_W-1:0] o_rd_idx
);
   logic [WIDTH-1:0] r_val [IN_W];
   logic [IDX_W-1:0] r_idx [IN_W];

   // Contents are don't-care after reset, so the storage carries no reset.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_val[i_wr_pw] <= i_wr_val;
         r_idx[i_wr_pw] <= i_wr_idx;
      end
   end

   assign o_rd_val = r_val[i_rd_pw];
   assign o_rd_idx = r_idx[i_rd_pw];
endmodule

// File: rtl/maxunpool2d_stream.sv
// Streaming max-unpool: buffers one pooled row, then emits its K output rows in raster order
// with each value at its argmax slot and zero elsewhere.
module maxunpool2d_stream
   import nn_pkg::*;
#(
   parameter int CH    = 1,
   parameter int IN_H  = 2,
   parameter int IN_W  = 2,
   parameter int K     = 2,
   parameter int WIDTH = Q_WIDTH,
   parameter int IDX_W = idx_width(K)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             idx_err
);
   localparam int PW_W = cnt_width(IN_W);
   localparam int K_W  = cnt_width(K);
   localparam int PH_W = cnt_width(IN_H);
   localparam int C_W  = cnt_width(CH);
   localparam logic [PW_W-1:0]  PW_MAX = PW_W'(IN_W - 1);
   localparam logic [K_W-1:0]   K_MAX  = K_W'(K - 1);
   localparam logic [PH_W-1:0]  PH_MAX = PH_W'(IN_H - 1);
   localparam logic [C_W-1:0]   C_MAX  = C_W'(CH - 1);
   localparam logic [IDX_W:0]   KK     = (IDX_W + 1)'(K * K);

   unpool_state_t    r_state, w_state_nx;
   logic [PW_W-1:0]  r_pw, w_pw_nx;
   logic [K_W-1:0]   r_kr, w_kr_nx, r_kw, w_kw_nx;
   logic [PH_W-1:0]  r_ph, w_ph_nx;
   logic [C_W-1:0]   r_c, w_c_nx;
   logic             r_in_ready, r_out_valid, w_out_valid_nx, r_out_last, w_out_last_nx;
   logic             r_idx_err, w_idx_err_nx;
   logic [WIDTH-1:0] r_out_data, w_out_data_nx, w_buf_val, w_rd_val;
   logic [IDX_W-1:0] w_buf_idx;
   logic             w_in_fire, w_out_fire, w_row_done, w_emit_load;
   int               w_tgt;

   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   assign w_row_done = (r_kr == K_MAX) && (r_pw == PW_MAX) && (r_kw == K_MAX);

   unpool_row_buf #(.IN_W(IN_W), .WIDTH(WIDTH), .IDX_W(IDX_W), .PW_W(PW_W)) u_row_buf (
      .i_clk    (clk),
      .i_wr_en  (w_in_fire),
      .i_wr_pw  (r_pw),
      .i_wr_val (in_data),
      .i_wr_idx (in_idx),
      .i_rd_pw  (w_pw_nx),
      .o_rd_val (w_buf_val),
      .o_rd_idx (w_buf_idx)
   );

   // With a one-entry row the completing write is read in the same cycle, so bypass it.
   assign w_rd_val = (w_in_fire && (r_pw == w_pw_nx)) ? in_data : w_buf_val;

   // State, counters and all outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_FILL;
         r_pw        <= {PW_W{1'b0}};
         r_kr        <= {K_W{1'b0}};
         r_kw        <= {K_W{1'b0}};
         r_ph        <= {PH_W{1'b0}};
         r_c         <= {C_W{1'b0}};
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= {WIDTH{1'b0}};
         r_out_last  <= 1'b0;
         r_idx_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_pw        <= w_pw_nx;
         r_kr        <= w_kr_nx;
         r_kw        <= w_kw_nx;
         r_ph        <= w_ph_nx;
         r_c         <= w_c_nx;
         r_in_ready  <= (w_state_nx == ST_FILL);
         r_out_valid <= w_out_valid_nx;
         r_out_data  <= w_out_data_nx;
         r_out_last  <= w_out_last_nx;
         r_idx_err   <= w_idx_err_nx;
      end
   end

   // Next-state: FILL until the row is complete, EMIT until its last output transfers.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_FILL: begin
            if (w_in_fire && (r_pw == PW_MAX)) w_state_nx = ST_EMIT;
            else                               w_state_nx = ST_FILL;
         end
         ST_EMIT: begin
            if (w_out_fire && w_row_done) w_state_nx = ST_FILL;
            else                          w_state_nx = ST_EMIT;
         end
         default: w_state_nx = ST_FILL;
      endcase
   end

   // Counters: kw fastest, then pw, then kr; ph/c move once per emitted row.
   always_comb begin
      w_pw_nx     = r_pw;
      w_kr_nx     = r_kr;
      w_kw_nx     = r_kw;
      w_ph_nx     = r_ph;
      w_c_nx      = r_c;
      w_emit_load = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (w_in_fire && (r_pw == PW_MAX)) begin
               w_pw_nx     = {PW_W{1'b0}};
               w_kr_nx     = {K_W{1'b0}};
               w_kw_nx     = {K_W{1'b0}};
               w_emit_load = 1'b1;
            end else if (w_in_fire) begin
               w_pw_nx = r_pw + PW_W'(1);
            end else begin
               w_pw_nx = r_pw;
            end
         end
         ST_EMIT: begin
            if (w_out_fire) begin
               if (r_kw != K_MAX) begin
                  w_kw_nx = r_kw + K_W'(1);
               end else begin
                  w_kw_nx = {K_W{1'b0}};
                  if (r_pw != PW_MAX) begin
                     w_pw_nx = r_pw + PW_W'(1);
                  end else begin
                     w_pw_nx = {PW_W{1'b0}};
                     w_kr_nx = (r_kr == K_MAX) ? {K_W{1'b0}} : r_kr + K_W'(1);
                  end
               end
               if (w_row_done) begin
                  w_ph_nx = (r_ph == PH_MAX) ? {PH_W{1'b0}} : r_ph + PH_W'(1);
                  if (r_ph == PH_MAX) w_c_nx = (r_c == C_MAX) ? {C_W{1'b0}} : r_c + C_W'(1);
                  else                w_c_nx = r_c;
               end else begin
                  w_emit_load = 1'b1;
               end
            end else begin
               w_emit_load = 1'b0;
            end
         end
         default: begin
            w_pw_nx = {PW_W{1'b0}};
            w_kr_nx = {K_W{1'b0}};
            w_kw_nx = {K_W{1'b0}};
         end
      endcase
   end

   // Output register next values and the sticky bad-index flag.
   always_comb begin
      w_tgt          = int'(w_kr_nx) * K + int'(w_kw_nx);
      w_out_valid_nx = r_out_valid;
      w_out_data_nx  = r_out_data;
      w_out_last_nx  = r_out_last;
      if (w_emit_load) begin
         w_out_valid_nx = 1'b1;
         w_out_data_nx  = (int'(w_buf_idx) == w_tgt) ? w_rd_val : {WIDTH{1'b0}};
         w_out_last_nx  = (w_kr_nx == K_MAX) && (w_pw_nx == PW_MAX) && (w_kw_nx == K_MAX)
                          && (r_ph == PH_MAX) && (r_c == C_MAX);
      end else if (w_out_fire) begin
         w_out_valid_nx = 1'b0;
         w_out_data_nx  = {WIDTH{1'b0}};
         w_out_last_nx  = 1'b0;
      end else begin
         w_out_valid_nx = r_out_valid;
      end
      w_idx_err_nx = r_idx_err || (w_in_fire && ({1'b0, in_idx} >= KK));
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign idx_err   = r_idx_err;
endmodule
